// File: rtl/if_pc_stage_if.sv
// Bundle between the fetch PC stage and its neighbours: predictor select/flush,
// recovery addresses, fetch-time prediction metadata, predictor lookup fields and the IF/ID register.
interface if_pc_stage_if #(
  parameter int INDEX_WIDTH   = 6,
  parameter int HISTORY_WIDTH = 8
);
  localparam int TAG_WIDTH = 32 - INDEX_WIDTH - 2;

  logic                     stall_i;
  logic                     imem_ready_i;
  logic [1:0]               PCnext_sel_i;
  logic                     flush_i;
  logic [31:0]              btb_target_i;
  logic [31:0]              EXMEM_pc_plus4_i;
  logic [31:0]              EXMEM_br_target_i;
  logic                     prediction_i;
  logic                     btb_hit_i;
  logic [HISTORY_WIDTH-1:0] ghr_data_i;

  logic [31:0]              IF_pc_o;
  logic [TAG_WIDTH-1:0]     IF_PC_tag_o;
  logic [INDEX_WIDTH-1:0]   IF_btb_rd_index_o;
  logic [HISTORY_WIDTH-1:0] IF_pht_rd_index_o;
  logic                     ID_valid_o;
  logic [31:0]              ID_pc_o;
  logic [31:0]              ID_pc_plus4_o;
  logic                     ID_prediction_o;
  logic                     ID_btb_hit_o;
  logic [HISTORY_WIDTH-1:0] ID_ghr_data_o;

  modport master (
    output stall_i, imem_ready_i, PCnext_sel_i, flush_i, btb_target_i,
           EXMEM_pc_plus4_i, EXMEM_br_target_i, prediction_i, btb_hit_i, ghr_data_i,
    input  IF_pc_o, IF_PC_tag_o, IF_btb_rd_index_o, IF_pht_rd_index_o,
           ID_valid_o, ID_pc_o, ID_pc_plus4_o, ID_prediction_o, ID_btb_hit_o, ID_ghr_data_o
  );

  modport slave (
    input  stall_i, imem_ready_i, PCnext_sel_i, flush_i, btb_target_i,
           EXMEM_pc_plus4_i, EXMEM_br_target_i, prediction_i, btb_hit_i, ghr_data_i,
    output IF_pc_o, IF_PC_tag_o, IF_btb_rd_index_o, IF_pht_rd_index_o,
           ID_valid_o, ID_pc_o, ID_pc_plus4_o, ID_prediction_o, ID_btb_hit_o, ID_ghr_data_o
  );
endinterface

// File: rtl/if_pc_stage.sv
// Fetch PC generator and IF/ID pipeline register; after a redirect it
// discards the stale response of a fetch that was still in flight.
module if_pc_stage #(
  parameter int          INDEX_WIDTH   = 6,
  parameter int          HISTORY_WIDTH = 8,
  parameter logic [31:0] RESET_PC      = 32'h0000_0000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  if_pc_stage_if.slave     bus
);
  typedef enum logic {RUN, DROP} state_t;

  state_t                   state;
  logic [31:0]              pc;
  logic [31:0]              redirect_pc;
  logic [31:0]              next_pc;
  logic                     adv;

  assign adv         = bus.imem_ready_i & ~bus.stall_i & (state == RUN);
  assign redirect_pc = (bus.PCnext_sel_i == 2'b11) ? bus.EXMEM_br_target_i : bus.EXMEM_pc_plus4_i;
  // Recovery selects (01/11) are only meaningful alongside a flush; otherwise fall through.
  assign next_pc     = (bus.PCnext_sel_i == 2'b10) ? bus.btb_target_i : pc + 32'd4;

  // NOTE: sequential state uses non-blocking assignments only, and the reset
  // is sampled on the clock edge (synchronous) rather than in the sensitivity list.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state               <= RUN;
      pc                  <= {RESET_PC[31:2], 2'b00};
      bus.ID_valid_o      <= 1'b0;
      bus.ID_pc_o         <= '0;
      bus.ID_pc_plus4_o   <= '0;
      bus.ID_prediction_o <= 1'b0;
      bus.ID_btb_hit_o    <= 1'b0;
      bus.ID_ghr_data_o   <= '0;
    end else if (bus.flush_i) begin
      pc                  <= {redirect_pc[31:2], 2'b00};
      bus.ID_valid_o      <= 1'b0;
      bus.ID_prediction_o <= 1'b0;
      bus.ID_btb_hit_o    <= 1'b0;
      bus.ID_ghr_data_o   <= '0;
      // A fetch not yet answered will return data for the old path.
      state               <= bus.imem_ready_i ? RUN : DROP;
    end else if (state == DROP) begin
      if (bus.imem_ready_i) state <= RUN;
    end else if (adv) begin
      pc                  <= {next_pc[31:2], 2'b00};
      bus.ID_valid_o      <= 1'b1;
      bus.ID_pc_o         <= pc;
      bus.ID_pc_plus4_o   <= pc + 32'd4;
      bus.ID_prediction_o <= bus.prediction_i;
      bus.ID_btb_hit_o    <= bus.btb_hit_i;
      bus.ID_ghr_data_o   <= bus.ghr_data_i;
    end else if (!bus.stall_i) begin
      bus.ID_valid_o      <= 1'b0;
    end
  end

  assign bus.IF_pc_o           = pc;
  assign bus.IF_PC_tag_o       = pc[31:INDEX_WIDTH+2];
  assign bus.IF_btb_rd_index_o = pc[INDEX_WIDTH+1:2];
  assign bus.IF_pht_rd_index_o = pc[HISTORY_WIDTH+1:2];
endmodule

// File: tb/tb_if_pc_stage.sv
// Bench for if_pc_stage: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_if_pc_stage;
  localparam int          IW = 6;
  localparam int          HW = 8;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  if_pc_stage_if #(.INDEX_WIDTH(IW), .HISTORY_WIDTH(HW)) bus ();

  if_pc_stage #(.INDEX_WIDTH(IW), .HISTORY_WIDTH(HW), .RESET_PC(RST_PC)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  // Behavioural model: architectural PC, IF/ID contents, and whether a stale
  // memory response is still owed after a redirect.
  longint unsigned m_pc;
  bit              m_valid;
  longint unsigned m_id_pc, m_id_pc4;
  bit              m_pred, m_hit;
  int unsigned     m_ghr;
  bit              m_stale_owed;

  function automatic longint unsigned align(longint unsigned a);
    return a - (a % 4);
  endfunction

  task automatic model_edge();
    if (!rst_n) begin
      m_pc = RST_PC; m_valid = 0; m_id_pc = 0; m_id_pc4 = 0;
      m_pred = 0; m_hit = 0; m_ghr = 0; m_stale_owed = 0;
    end else if (bus.flush_i) begin
      m_pc = align(bus.PCnext_sel_i == 2'd3 ? bus.EXMEM_br_target_i : bus.EXMEM_pc_plus4_i);
      m_valid = 0; m_pred = 0; m_hit = 0; m_ghr = 0;
      m_stale_owed = !bus.imem_ready_i;
    end else if (m_stale_owed) begin
      if (bus.imem_ready_i) m_stale_owed = 0;
    end else if (bus.stall_i) begin
      // everything holds
    end else if (bus.imem_ready_i) begin
      m_valid  = 1;
      m_id_pc  = m_pc;
      m_id_pc4 = (m_pc + 4) % 64'h1_0000_0000;
      m_pred   = bus.prediction_i;
      m_hit    = bus.btb_hit_i;
      m_ghr    = bus.ghr_data_i;
      m_pc     = (bus.PCnext_sel_i == 2'd2) ? align(bus.btb_target_i) : (m_pc + 4) % 64'h1_0000_0000;
    end else begin
      m_valid = 0;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("IF_pc",        bus.IF_pc_o, 32'(m_pc));
    check("IF_tag",       32'(bus.IF_PC_tag_o), 32'(m_pc / (64'd1 << (IW + 2))));
    check("IF_btb_index", 32'(bus.IF_btb_rd_index_o), 32'((m_pc / 4) % (64'd1 << IW)));
    check("IF_pht_index", 32'(bus.IF_pht_rd_index_o), 32'((m_pc / 4) % (64'd1 << HW)));
    check("ID_valid",     32'(bus.ID_valid_o), 32'(m_valid));
    check("ID_pc",        bus.ID_pc_o, 32'(m_id_pc));
    check("ID_pc_plus4",  bus.ID_pc_plus4_o, 32'(m_id_pc4));
    check("ID_prediction",32'(bus.ID_prediction_o), 32'(m_pred));
    check("ID_btb_hit",   32'(bus.ID_btb_hit_o), 32'(m_hit));
    check("ID_ghr",       32'(bus.ID_ghr_data_o), m_ghr);
  endtask

  // Model advances with the pre-edge inputs; outputs are compared 1ns after the edge.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic drive(input bit fl, input logic [1:0] sel, input bit st, input bit rdy);
    bus.flush_i = fl; bus.PCnext_sel_i = sel; bus.stall_i = st; bus.imem_ready_i = rdy;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 2'b00, 0, 1);
    bus.btb_target_i = '0; bus.EXMEM_pc_plus4_i = '0; bus.EXMEM_br_target_i = '0;
    bus.prediction_i = 0; bus.btb_hit_i = 0; bus.ghr_data_i = '0;
    m_pc = 0; m_valid = 0; m_id_pc = 0; m_id_pc4 = 0;
    m_pred = 0; m_hit = 0; m_ghr = 0; m_stale_owed = 0;
    @(negedge clk);

    // Reset state
    step();
    check("reset_pc", bus.IF_pc_o, 32'h0);
    check("reset_valid", 32'(bus.ID_valid_o), 32'h0);

    // Sequential fetch 0,4,8,C
    rst_n = 1'b1;
    step(); step(); step();
    check("seq_pc_C", bus.IF_pc_o, 32'hC);
    check("seq_id_pc_8", bus.ID_pc_o, 32'h8);
    check("seq_valid", 32'(bus.ID_valid_o), 32'h1);

    // BTB-predicted jump from 0x40 to 0x100
    drive(1, 2'b01, 0, 1); bus.EXMEM_pc_plus4_i = 32'h40; step();
    drive(0, 2'b10, 0, 1);
    bus.btb_target_i = 32'h100; bus.prediction_i = 1; bus.btb_hit_i = 1; bus.ghr_data_i = 8'hA5;
    step();
    check("btb_pc", bus.IF_pc_o, 32'h100);
    check("btb_id_pc", bus.ID_pc_o, 32'h40);
    check("btb_id_pred", 32'(bus.ID_prediction_o), 32'h1);
    check("btb_id_ghr", 32'(bus.ID_ghr_data_o), 32'hA5);
    bus.prediction_i = 0; bus.btb_hit_i = 0; bus.ghr_data_i = '0;

    // Stall at PC=0x20 for three cycles, then resume
    drive(1, 2'b01, 0, 1); bus.EXMEM_pc_plus4_i = 32'h1C; step();
    drive(0, 2'b00, 0, 1); step();
    drive(0, 2'b00, 1, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc", bus.IF_pc_o, 32'h20);
      check("stall_id_pc", bus.ID_pc_o, 32'h1C);
    end
    drive(0, 2'b00, 0, 1); step();
    check("resume_pc", bus.IF_pc_o, 32'h24);

    // Flush beats stall; no IF/ID capture
    drive(1, 2'b11, 1, 1); bus.EXMEM_br_target_i = 32'h200; step();
    check("flush_pc", bus.IF_pc_o, 32'h200);
    check("flush_valid", 32'(bus.ID_valid_o), 32'h0);
    check("flush_no_capture", bus.ID_pc_o, 32'h20);

    // Flush with fetch in flight: first ready dropped
    drive(1, 2'b01, 0, 0); bus.EXMEM_pc_plus4_i = 32'h84; step();
    drive(0, 2'b00, 0, 0); step();
    drive(0, 2'b00, 0, 1); step();
    check("drop_pc", bus.IF_pc_o, 32'h84);
    check("drop_valid", 32'(bus.ID_valid_o), 32'h0);
    step();
    check("after_drop_id_pc", bus.ID_pc_o, 32'h84);
    check("after_drop_valid", 32'(bus.ID_valid_o), 32'h1);

    // Wrap at top of address space, then reset during DROP
    drive(1, 2'b01, 0, 1); bus.EXMEM_pc_plus4_i = 32'hFFFF_FFFC; step();
    drive(0, 2'b00, 0, 1); step();
    check("wrap_pc", bus.IF_pc_o, 32'h0);
    drive(1, 2'b01, 0, 0); bus.EXMEM_pc_plus4_i = 32'h300; step();
    drive(0, 2'b00, 0, 1); rst_n = 1'b0; step();
    check("rst_drop_pc", bus.IF_pc_o, RST_PC);
    check("rst_drop_valid", 32'(bus.ID_valid_o), 32'h0);
    rst_n = 1'b1; step();
    check("rst_drop_run", bus.IF_pc_o, 32'h4);

    // Unaligned redirect target gets its low bits cleared
    drive(1, 2'b01, 0, 1); bus.EXMEM_pc_plus4_i = 32'h87; step();
    check("align_pc", bus.IF_pc_o, 32'h84);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst_n                 = ($urandom_range(99) >= 2);
      bus.flush_i           = ($urandom_range(99) < 10);
      bus.stall_i           = ($urandom_range(99) < 25);
      bus.imem_ready_i      = ($urandom_range(99) < 70);
      bus.PCnext_sel_i      = 2'($urandom_range(3));
      bus.btb_target_i      = $urandom;
      bus.EXMEM_pc_plus4_i  = ($urandom_range(9) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(7)) : $urandom;
      bus.EXMEM_br_target_i = $urandom;
      bus.prediction_i      = 1'($urandom);
      bus.btb_hit_i         = 1'($urandom);
      bus.ghr_data_i        = 8'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
